// File: rtl/traffic_light_fsm.sv
// Moore traffic-light controller: GREEN -> YELLOW -> RED -> GREEN on request a,
// with per-state dwell timer enforcing minimum green, exact yellow and minimum red.
module traffic_light_fsm #(
   parameter int GREEN_MIN     = 2,
   parameter int YELLOW_CYCLES = 2,
   parameter int RED_CYCLES    = 4,
   parameter int CNT_W         = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   output logic green,
   output logic red,
   output logic yellow
);

   typedef enum logic [1:0] {
      S_GREEN  = 2'b00,
      S_YELLOW = 2'b01,
      S_RED    = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RED_CYCLES - 1);
   localparam logic [CNT_W-1:0] T_MAX  = {CNT_W{1'b1}};

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] timer_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_GREEN;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_GREEN: begin
            if (a && (timer >= G_LAST))
               state_nxt = S_YELLOW;
         end
         S_YELLOW: begin
            if (timer >= Y_LAST)
               state_nxt = S_RED;
         end
         S_RED: begin
            if (!a && (timer >= R_LAST))
               state_nxt = S_GREEN;
         end
         default: state_nxt = S_GREEN;
      endcase
   end

   // Saturate rather than wrap so an indefinitely held red stays legal.
   always_comb begin
      timer_nxt = timer;
      if (state_nxt != state)
         timer_nxt = '0;
      else if (timer != T_MAX)
         timer_nxt = timer + 1'b1;
   end

   assign green  = (state == S_GREEN);
   assign yellow = (state == S_YELLOW);
   assign red    = (state == S_RED);

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: lamp sequence, dwell times,
// async reset and a continuous one-hot check.
module tb_traffic_light_fsm;

   logic clk;
   logic rst;
   logic a;
   logic green;
   logic red;
   logic yellow;
   logic [2:0] lamps;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] LG = 3'b100;
   localparam logic [2:0] LY = 3'b010;
   localparam logic [2:0] LR = 3'b001;

   traffic_light_fsm dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .green  (green),
      .red    (red),
      .yellow (yellow)
   );

   assign lamps = {green, yellow, red};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [2:0] got,
                        input logic [2:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk)
      check("onehot", 3'($countones(lamps)), 3'd1);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic a_after);
      rst = 1'b0;
      a   = 1'b0;
      step();
      step();
      check("rst_hold", lamps, LG);
      rst = 1'b1;
      a   = a_after;
   endtask

   initial begin
      rst = 1'b0;
      a   = 1'b0;
      #2;
      check("rst_init", lamps, LG);

      // test 1: async reset from RED between edges
      do_reset(1'b1);
      step();
      step();
      step();
      step();
      check("t1_red", lamps, LR);
      #3;
      rst = 1'b0;
      #1;
      check("t1_async", lamps, LG);
      step();
      step();
      check("t1_held", lamps, LG);

      // test 2: idle
      do_reset(1'b0);
      for (int i = 0; i < 20; i++) begin
         step();
         check("t2_idle", lamps, LG);
      end

      // test 3: full cycle with a held high
      do_reset(1'b1);
      check("t3_g0", lamps, LG);
      step();
      check("t3_g1", lamps, LG);
      step();
      check("t3_y0", lamps, LY);
      step();
      check("t3_y1", lamps, LY);
      step();
      check("t3_r0", lamps, LR);
      for (int i = 0; i < 10; i++) begin
         step();
         check("t3_rhold", lamps, LR);
      end
      a = 1'b0;
      step();
      check("t3_back", lamps, LG);

      // test 4: short red request
      do_reset(1'b1);
      step();
      step();
      check("t4_y0", lamps, LY);
      a = 1'b0;
      step();
      check("t4_y1", lamps, LY);
      step();
      check("t4_r0", lamps, LR);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t4_rmin", lamps, LR);
      end
      step();
      check("t4_g", lamps, LG);
      step();
      check("t4_gstay", lamps, LG);

      // test 5: early request is not latched
      do_reset(1'b1);
      step();
      a = 1'b0;
      check("t5_g", lamps, LG);
      for (int i = 0; i < 10; i++) begin
         step();
         check("t5_stay", lamps, LG);
      end

      // test 6: a toggling during yellow
      do_reset(1'b1);
      step();
      step();
      check("t6_y0", lamps, LY);
      a = 1'b0;
      step();
      check("t6_y1", lamps, LY);
      a = 1'b1;
      step();
      check("t6_r", lamps, LR);
      a = 1'b0;
      step();
      check("t6_r1", lamps, LR);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Three-state Moore traffic-light controller driving one-hot green/yellow/red lamp outputs.
- Request input `a` (e.g. vehicle/pedestrian sensor) triggers the sequence GREEN → YELLOW → RED → GREEN.
- Per-state dwell timers enforce minimum green time, fixed yellow time and minimum red time.
- Leaf block; outputs drive lamp drivers directly.

Parameters:
- GREEN_MIN, 2, minimum cycles spent in GREEN before a request is honoured (≥1)
- YELLOW_CYCLES, 2, exact cycles spent in YELLOW (≥1)
- RED_CYCLES, 4, minimum cycles spent in RED (≥1)
- CNT_W, 8, dwell-timer width; every duration parameter must be ≤ 2^CNT_W−1

Ports:
- clk, input, 1, system clock; all state updates on rising edge
- rst, input, 1, asynchronous active-low reset
- a, input, 1, request; synchronous to clk, sampled on rising edge
- green, output, 1, green lamp, active-high
- red, output, 1, red lamp, active-high
- yellow, output, 1, yellow lamp, active-high

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-low.
- States: S_GREEN, S_YELLOW, S_RED. Encoding is free, but the outputs must be a pure decode of the state register (Moore), with no combinational path from `a`.
- Reset (rst=0): takes effect immediately, with no clock edge needed.
  - state=S_GREEN, timer=0.
  - green=1, yellow=0, red=0.
  - Held while rst=0.
  - Reset mid-YELLOW or mid-RED forces GREEN at once.
- Outputs are exactly one-hot at all times: green=1 iff S_GREEN, yellow=1 iff S_YELLOW, red=1 iff S_RED.
- Dwell timer:
  - Cleared to 0 on every state change.
  - Otherwise increments by 1 per cycle.
  - Saturates at 2^CNT_W−1 (no wrap).
- S_GREEN:
  - If a=1 and timer ≥ GREEN_MIN−1 → S_YELLOW.
  - Otherwise stay.
  - Result: green lasts at least GREEN_MIN cycles.
  - a=1 before the minimum is not latched; it must still be high when the minimum elapses.
- S_YELLOW:
  - When timer = YELLOW_CYCLES−1 → S_RED unconditionally.
  - `a` is ignored in this state.
  - Yellow is exactly YELLOW_CYCLES cycles.
- S_RED:
  - When timer ≥ RED_CYCLES−1 and a=0 → S_GREEN.
  - While a=1, red is held indefinitely; the saturating timer prevents wrap.
  - Red lasts at least RED_CYCLES cycles.
- Illegal or unreachable state encoding → S_GREEN on the next edge, timer cleared.
- Transition latency: the output changes on the same rising edge at which the transition condition is sampled true.
- No other outputs; no handshake.

Test Plan:
1. Async reset: reach S_RED, then drive rst=0 between clock edges → green=1, yellow=0, red=0 immediately, before any edge. Outputs held while rst=0.
2. Idle: release rst with a=0 and run 20 cycles → green=1, yellow=0, red=0 every cycle.
3. Full cycle (defaults), a=1 from reset release:
   - green for 2 edges, then yellow for exactly 2 cycles, then red.
   - Keep a=1 for 10 red cycles → red stays.
   - Drop a=0 → green=1 on the next edge.
4. Short red request: a=1 until yellow is entered, then a=0 → red exactly 4 cycles, then green.
5. Early request ignored: single-cycle a=1 pulse in the first green cycle (timer=0), then a=0 → stays green, never enters yellow.
6. `a` toggling every cycle during YELLOW → yellow still exactly 2 cycles. One-hot check (green+yellow+red == 1) asserted on every cycle of every test.
